// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin arbiter of fetch and data ports onto one fixed-latency memory
module unified_mem_arbiter #(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_ready,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ready,
  output logic                 mem_readM,
  output logic                 mem_writeM,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] num_i_access,
  output logic [WORD_SIZE-1:0] num_d_access
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  state_t     state, state_n;
  logic [3:0] cnt;
  logic       last_grant;  // 0 = fetch won last, 1 = data won last
  logic       we_q;
  logic       grant_i, grant_d;

  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state)
      IDLE: begin
        if (i_req && d_req) begin
          grant_i = last_grant;
          grant_d = !last_grant;
        end else begin
          grant_d = d_req;
          grant_i = i_req;
        end
        if (grant_d)      state_n = BUSY_D;
        else if (grant_i) state_n = BUSY_I;
      end
      BUSY_I, BUSY_D: if (cnt == 4'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    i_ready = (state == BUSY_I) && (cnt == 4'd0);
    d_ready = (state == BUSY_D) && (cnt == 4'd0);
    i_rdata = i_ready ? mem_rdata : '0;
    // A completed write returns zero rather than whatever the memory drives.
    d_rdata = (d_ready && !we_q) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      last_grant   <= 1'b0;
      we_q         <= 1'b0;
      mem_readM    <= 1'b0;
      mem_writeM   <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      num_i_access <= '0;
      num_d_access <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        if (grant_d) begin
          mem_address  <= d_addr;
          mem_wdata    <= d_wdata;
          we_q         <= d_we;
          mem_readM    <= !d_we;
          mem_writeM   <= d_we;
          cnt          <= CNT_INIT;
          last_grant   <= 1'b1;
          num_d_access <= num_d_access + 1'b1;
        end else if (grant_i) begin
          mem_address  <= i_addr;
          mem_wdata    <= '0;
          we_q         <= 1'b0;
          mem_readM    <= 1'b1;
          mem_writeM   <= 1'b0;
          cnt          <= CNT_INIT;
          last_grant   <= 1'b0;
          num_i_access <= num_i_access + 1'b1;
        end
      end else if (cnt == 4'd0) begin
        mem_readM  <= 1'b0;
        mem_writeM <= 1'b0;
      end else begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - vector table plus scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata, num_i_access, num_d_access;
  logic        i_ready, d_ready, mem_readM, mem_writeM;

  logic        i_req2, d_req2, d_we2;
  logic [7:0]  i_addr2, d_addr2, d_wdata2, mem_rdata2;
  logic [7:0]  i_rdata2, d_rdata2, mem_address2, mem_wdata2, num_i2, num_d2;
  logic        i_ready2, d_ready2, mem_readM2, mem_writeM2;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_readM(mem_readM), .mem_writeM(mem_writeM), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .num_i_access(num_i_access), .num_d_access(num_d_access)
  );

  unified_mem_arbiter #(.WORD_SIZE(8), .MEM_LATENCY(1)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_ready(i_ready2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_ready(d_ready2),
    .mem_readM(mem_readM2), .mem_writeM(mem_writeM2), .mem_address(mem_address2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .num_i_access(num_i2), .num_d_access(num_d2)
  );

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] mem_val;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic [15:0] rdata;
  } sb_t;

  sb_t         sbq[$];
  sb_t         e_mon;
  vec_t        vecs[5];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ni = 0, exp_nd = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (i_ready || d_ready) begin
        chk("ready_exclusive", 32'(i_ready && d_ready), 0);
        if (sbq.size() == 0) begin
          chk("spurious_ready", 1, 0);
        end else begin
          e_mon = sbq.pop_front();
          chk("sb_side", 32'(d_ready), 32'(e_mon.is_d));
          chk("sb_rdata", 32'(d_ready ? d_rdata : i_rdata), 32'(e_mon.rdata));
        end
      end else begin
        chk("rdata_zero_idle", {i_rdata, d_rdata}, 0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_strobes"}, {mem_readM, mem_writeM, i_ready, d_ready}, 0);
    chk({tag, "_bus"}, {mem_address, mem_wdata}, 0);
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
    chk({tag, "_counters"}, {num_i_access, num_d_access}, 0);
  endtask

  task automatic check_counters(input string tag);
    chk({tag, "_num_i"}, 32'(num_i_access), 32'(exp_ni));
    chk({tag, "_num_d"}, 32'(num_d_access), 32'(exp_nd));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [1:0] rdy_exp;
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; exp_nd++;
    end else begin
      i_req = 1'b1; i_addr = v.addr; exp_ni++;
    end
    mem_rdata = v.mem_val;
    sbq.push_back('{v.is_d, v.exp_rdata});
    @(negedge clk);
    chk($sformatf("v%0d_c0_strobe", idx), {mem_readM, mem_writeM}, 0);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_c%0d_strobe", idx, c), {mem_readM, mem_writeM}, {v.exp_rd, v.exp_wr});
      chk($sformatf("v%0d_c%0d_addr", idx, c), 32'(mem_address), 32'(v.addr));
      if (v.we) chk($sformatf("v%0d_c%0d_wdata", idx, c), 32'(mem_wdata), 32'(v.wdata));
      rdy_exp = (c == LAT) ? (v.is_d ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("v%0d_c%0d_ready", idx, c), {i_ready, d_ready}, 32'(rdy_exp));
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_after_strobe", idx), {mem_readM, mem_writeM, i_ready, d_ready}, 0);
    check_counters($sformatf("v%0d", idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [1:0]  rdy_exp;
    logic [15:0] addr_exp;

    reset_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    i_req2 = 0; d_req2 = 0; d_we2 = 0; i_addr2 = 0; d_addr2 = 0; d_wdata2 = 0; mem_rdata2 = 8'h3C;

    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hABCD, 1'b1, 1'b0, 16'hABCD};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h5555, 1'b0, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'h0030, 16'h9999, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'h0001};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    chk("reset_dut2", {num_i2, num_d2, mem_readM2, i_ready2, d_ready2}, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Both sides held high from reset: D, I, D with readies in cycles 2, 5, 8.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h0100; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    mem_rdata = 16'h7777;
    sbq.push_back('{1'b1, 16'h7777});
    sbq.push_back('{1'b0, 16'h7777});
    sbq.push_back('{1'b1, 16'h7777});
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      rdy_exp = (c == 2 || c == 8) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
      chk($sformatf("tie_c%0d_ready", c), {i_ready, d_ready}, 32'(rdy_exp));
      if (c == 1 || c == 2 || c == 4 || c == 5 || c == 7 || c == 8) begin
        addr_exp = (c == 4 || c == 5) ? 16'h0100 : 16'h0200;
        chk($sformatf("tie_c%0d_addr", c), 32'(mem_address), 32'(addr_exp));
        chk($sformatf("tie_c%0d_rd", c), 32'(mem_readM), 1);
      end
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    exp_ni = 1; exp_nd = 2;
    @(negedge clk);
    check_counters("tie");

    for (int k = 0; k < 5; k++) run_vec(vecs[k], k);

    // Fetch address changes and request drops in the first busy cycle.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h0040; mem_rdata = 16'h4242;
    sbq.push_back('{1'b0, 16'h4242});
    exp_ni++;
    @(posedge clk); #1;
    i_addr = 16'h0999; i_req = 1'b0;
    @(negedge clk);
    chk("midchg_c1_addr", 32'(mem_address), 32'h0040);
    @(negedge clk);
    chk("midchg_c2_addr", 32'(mem_address), 32'h0040);
    chk("midchg_c2_ready", 32'(i_ready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midchg_after", {mem_readM, mem_writeM, i_ready, d_ready}, 0);
    check_counters("midchg");

    // Reset during the first busy cycle of a data read.
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050; mem_rdata = 16'h5050;
    @(posedge clk); #1;
    reset_n = 1'b0; d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1 reset_n = 1'b1;
    exp_ni = 0; exp_nd = 0;

    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 16'h0300; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
    mem_rdata = 16'h6161;
    sbq.push_back('{1'b1, 16'h6161});
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      rdy_exp = (c == 2) ? 2'b01 : 2'b00;
      chk($sformatf("rsttie_c%0d_ready", c), {i_ready, d_ready}, 32'(rdy_exp));
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
    exp_nd = 1;
    @(negedge clk);
    check_counters("rsttie");

    // Counter wrap on the narrow single-cycle-latency instance.
    n = 0;
    i_req2 = 1'b1; i_addr2 = 8'h5A;
    for (int k = 0; k < 2000 && n < 256; k++) begin
      @(negedge clk);
      if (i_ready2) begin
        n++;
        if (n == 1) begin
          chk("lat1_strobe_with_ready", {mem_readM2, mem_address2}, {1'b1, 8'h5A});
          chk("lat1_rdata", 32'(i_rdata2), 32'h3C);
        end
        if (n == 255) chk("wrap_num_i_ff", 32'(num_i2), 32'hFF);
        if (n == 256) begin
          chk("wrap_num_i_00", 32'(num_i2), 32'h00);
          chk("wrap_num_d", 32'(num_d2), 32'h00);
        end
      end
    end
    chk("wrap_grant_count", n, 256);
    @(posedge clk); #1 i_req2 = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates the pipeline's instruction-fetch port and data-memory port onto a single shared memory with fixed multi-cycle latency. The block sits between the pipelined datapath (IF and MEM stages) and the unified memory. It latches one request at a time, drives the memory bus for the full access latency, and returns a one-cycle ready pulse to the winning side. Simultaneous requests are resolved round-robin, and per-side access counters are kept for performance reporting.

## Interface
Parameters:
- `WORD_SIZE`, 16: data and address width.
- `MEM_LATENCY`, 2: memory access cycles per transaction. Legal range is 1–15.

Ports:
- `clk` input, 1: single clock. All state updates on posedge.
- `reset_n` input, 1: reset, synchronous, active-low.
- `i_req` input, 1: fetch read request. Held high until `i_ready`.
- `i_addr` input, WORD_SIZE: fetch address.
- `i_rdata` output, WORD_SIZE: fetched word. Valid only while `i_ready`=1.
- `i_ready` output, 1: one-cycle completion pulse for fetch.
- `d_req` input, 1: data request. Held high until `d_ready`.
- `d_we` input, 1: 1 = write, 0 = read.
- `d_addr` input, WORD_SIZE: data address.
- `d_wdata` input, WORD_SIZE: store data.
- `d_rdata` output, WORD_SIZE: load data. Valid only while `d_ready`=1.
- `d_ready` output, 1: one-cycle completion pulse for data.
- `mem_readM` output, 1: memory read strobe.
- `mem_writeM` output, 1: memory write strobe.
- `mem_address` output, WORD_SIZE: memory address.
- `mem_wdata` output, WORD_SIZE: memory write data.
- `mem_rdata` input, WORD_SIZE: memory read data. Valid in the final busy cycle.
- `num_i_access` output, WORD_SIZE: granted fetch count.
- `num_d_access` output, WORD_SIZE: granted data count.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. The state, a 4-bit countdown `cnt`, and `last_grant` (I/D) are registered.
- IDLE behaviour:
  - All memory strobes are 0.
  - The grant is decided at the posedge from the sampled requests:
    - only `d_req` → D;
    - only `i_req` → I;
    - both → the side opposite `last_grant`;
    - none → stay in IDLE.
- On grant:
  - Latch the address (and `d_we`/`d_wdata` for D) into bus registers.
  - Set `cnt` = MEM_LATENCY-1.
  - Set `last_grant` to the winner.
  - Increment the matching access counter.
  - Enter BUSY_I or BUSY_D.
- BUSY_x:
  - Drive `mem_address`/`mem_wdata` from the latched registers.
  - `mem_readM` = 1 for I or for D-read. `mem_writeM` = 1 for D-write.
  - Decrement `cnt` each cycle.
  - When `cnt`==0 (final cycle), pulse the matching `x_ready` and pass `x_rdata` = `mem_rdata`. For a D-write, `d_rdata` = 0.
  - At the next edge, return to IDLE unconditionally. This gives one dead cycle between transactions.
- Requester inputs are ignored during BUSY; the latched values are used.
- A request dropped mid-transaction does not abort it. The transaction completes and the ready pulse still fires.
- `x_rdata` is 0 whenever `x_ready` is 0.
- The `x_ready` pulses are mutually exclusive, and each is at most 1 cycle wide.
- The counters are WORD_SIZE bits and wrap from 0xFFFF to 0 without saturating.
- Reset (`reset_n`=0 at a posedge) applies in any state, including mid-BUSY:
  - state = IDLE, `cnt` = 0, `last_grant` = I;
  - all bus registers and counters = 0;
  - no ready pulse for the aborted transaction.

## Timing
- Reset values of every output:
  - `mem_readM`=0, `mem_writeM`=0, `mem_address`=0, `mem_wdata`=0;
  - `i_ready`=0, `d_ready`=0, `i_rdata`=0, `d_rdata`=0;
  - `num_i_access`=0, `num_d_access`=0.
- The first tie after reset goes to D, because `last_grant` resets to I.
- Latency: if a request is sampled in IDLE cycle t, the bus is active in cycles t+1..t+MEM_LATENCY and ready is asserted in cycle t+MEM_LATENCY.
- The FSM is back in IDLE at t+MEM_LATENCY+1, so the next grant edge is the end of that cycle.
- Throughput: at most one transaction per MEM_LATENCY+1 cycles.
- `mem_*` outputs are registered. `x_ready`/`x_rdata` are combinational from state, `cnt` and `mem_rdata`.
- With MEM_LATENCY=1, BUSY lasts one cycle and ready is in the same cycle as the strobe.

## Test plan
- Fetch, MEM_LATENCY=2:
  - Stimulus: `i_req`=1, `i_addr`=0x0010 in cycle 0; memory returns 0xABCD.
  - Required: `mem_readM`=1 with address 0x0010 in cycles 1–2; `i_ready`=1 with `i_rdata`=0xABCD in cycle 2 only; `num_i_access`=1.
- Tie sequence after reset:
  - Stimulus: `i_req` and `d_req` both held high.
  - Required: grant order D, I, D, with ready pulses in cycles 2, 5 and 8.
- Data write:
  - Stimulus: `d_req`=1, `d_we`=1, `d_addr`=0x0020, `d_wdata`=0x1234.
  - Required: `mem_writeM`=1 and `mem_readM`=0 for 2 cycles with the latched address/data; `d_ready` in cycle 2 with `d_rdata`=0.
- Input changes mid-transaction:
  - Stimulus: `i_addr` changed and `i_req` dropped in cycle 1 of BUSY_I.
  - Required: `mem_address` stays at the original value; `i_ready` still pulses.
- Reset mid-BUSY_D:
  - Stimulus: `reset_n`=0 in the first busy cycle.
  - Required: next cycle has all outputs 0 and no `d_ready`; a subsequent tie grants D.
- Counter wrap:
  - Stimulus: preload via 65535 fetch grants, then one more.
  - Required: `num_i_access` reads 0xFFFF, then 0x0000; `num_d_access` is unchanged.
